// File: rtl/axi4_slave_write_channel_if.sv
// Bus bundle for the AXI4 write-channel responder: AW/W/B toward the external master
// plus the inner per-beat write port. The "master" modport is everything around the responder.
interface axi4_slave_write_channel_if #(
  parameter int AddressWidth = 32,
  parameter int DataWidth    = 32
);
  logic [AddressWidth-1:0]  S_AWADDR;
  logic [7:0]               S_AWLEN;
  logic [2:0]               S_AWSIZE;
  logic [1:0]               S_AWBURST;
  logic                     S_AWVALID;
  logic                     S_AWREADY;
  logic [DataWidth-1:0]     S_WDATA;
  logic [DataWidth/8-1:0]   S_WSTRB;
  logic                     S_WLAST;
  logic                     S_WVALID;
  logic                     S_WREADY;
  logic [1:0]               S_BRESP;
  logic                     S_BVALID;
  logic                     S_BREADY;
  logic [AddressWidth-1:0]  INNER_WADDR;
  logic [DataWidth-1:0]     INNER_WDATA;
  logic [DataWidth/8-1:0]   INNER_WSTRB;
  logic                     INNER_WLAST;
  logic                     INNER_WVALID;
  logic                     INNER_WREADY;

  modport slave (
    input  S_AWADDR, S_AWLEN, S_AWSIZE, S_AWBURST, S_AWVALID,
    input  S_WDATA, S_WSTRB, S_WLAST, S_WVALID, S_BREADY, INNER_WREADY,
    output S_AWREADY, S_WREADY, S_BRESP, S_BVALID,
    output INNER_WADDR, INNER_WDATA, INNER_WSTRB, INNER_WLAST, INNER_WVALID
  );

  modport master (
    output S_AWADDR, S_AWLEN, S_AWSIZE, S_AWBURST, S_AWVALID,
    output S_WDATA, S_WSTRB, S_WLAST, S_WVALID, S_BREADY, INNER_WREADY,
    input  S_AWREADY, S_WREADY, S_BRESP, S_BVALID,
    input  INNER_WADDR, INNER_WDATA, INNER_WSTRB, INNER_WLAST, INNER_WVALID
  );
endinterface

// File: rtl/axi4_slave_write_channel.sv
// AXI4 write responder, one burst outstanding; replays each W beat on the inner port.
// Optional macro AXI4_SLAVE_WR_PROTOCOL_CHECK_EN adds WLAST/burst-type checking with SLVERR.
module axi4_slave_write_channel #(
  parameter int AddressWidth = 32,
  parameter int DataWidth    = 32
) (
  input logic                        ACLK,
  input logic                        ARESETN,
  axi4_slave_write_channel_if.slave  io_bus
);
  localparam logic [AddressWidth-1:0] BeatBytes = AddressWidth'(DataWidth / 8);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [AddressWidth-1:0] r_addr;
  logic [7:0]              r_len;
  logic [7:0]              r_beat;
  logic [1:0]              r_burst;
  logic                    r_err;
  logic                    r_drain;

  logic       w_awready;
  logic       w_wready;
  logic       w_bvalid;
  logic [1:0] w_bresp;
  logic       w_inner_wvalid;
  logic       w_inner_wlast;
  logic       w_last_beat;
  logic       w_beat_hs;
  logic       w_aw_bad;
  logic       w_wlast_bad;
  logic       w_unused;

  assign w_last_beat = (r_beat == r_len);
  // w_wready is only ever high in DATA, so this is a DATA-state beat
  assign w_beat_hs   = io_bus.S_WVALID & w_wready;

`ifdef AXI4_SLAVE_WR_PROTOCOL_CHECK_EN
  assign w_aw_bad    = io_bus.S_AWBURST[1];
  assign w_wlast_bad = io_bus.S_WLAST ^ w_last_beat;
`else
  assign w_aw_bad    = 1'b0;
  assign w_wlast_bad = 1'b0;
`endif

  assign w_unused = ^{io_bus.S_AWSIZE, io_bus.S_WLAST};

  // State register
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and handshake outputs decoded from the current state
  always_comb begin
    w_next         = r_state;
    w_awready      = 1'b0;
    w_wready       = 1'b0;
    w_bvalid       = 1'b0;
    w_bresp        = 2'b00;
    w_inner_wvalid = 1'b0;
    w_inner_wlast  = 1'b0;
    case (r_state)
      IDLE: begin
        w_awready = 1'b1;
        if (io_bus.S_AWVALID) begin
          w_next = DATA;
        end else begin
          w_next = IDLE;
        end
      end
      DATA: begin
        // Unsupported bursts are drained without reaching the inner port
        w_wready       = r_drain ? 1'b1 : io_bus.INNER_WREADY;
        w_inner_wvalid = io_bus.S_WVALID & ~r_drain;
        w_inner_wlast  = w_last_beat;
        if (w_beat_hs && w_last_beat) begin
          w_next = RESP;
        end else begin
          w_next = DATA;
        end
      end
      RESP: begin
        w_bvalid = 1'b1;
        w_bresp  = r_err ? 2'b10 : 2'b00;
        if (io_bus.S_BREADY) begin
          w_next = IDLE;
        end else begin
          w_next = RESP;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Burst context: captured at AW, advanced on every accepted beat
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      r_addr  <= '0;
      r_len   <= 8'd0;
      r_beat  <= 8'd0;
      r_burst <= 2'b00;
      r_err   <= 1'b0;
      r_drain <= 1'b0;
    end else if (r_state == IDLE && io_bus.S_AWVALID) begin
      r_addr  <= io_bus.S_AWADDR;
      r_len   <= io_bus.S_AWLEN;
      r_burst <= io_bus.S_AWBURST;
      r_beat  <= 8'd0;
      r_err   <= w_aw_bad;
      r_drain <= w_aw_bad;
    end else if (w_beat_hs) begin
      r_beat <= r_beat + 8'd1;
      if (r_burst != 2'b00) begin
        r_addr <= r_addr + BeatBytes;
      end
      if (w_wlast_bad) begin
        r_err <= 1'b1;
      end
    end
  end

  assign io_bus.S_AWREADY    = w_awready;
  assign io_bus.S_WREADY     = w_wready;
  assign io_bus.S_BVALID     = w_bvalid;
  assign io_bus.S_BRESP      = w_bresp;
  assign io_bus.INNER_WVALID = w_inner_wvalid;
  assign io_bus.INNER_WLAST  = w_inner_wlast;
  assign io_bus.INNER_WADDR  = r_addr;
  assign io_bus.INNER_WDATA  = io_bus.S_WDATA;
  assign io_bus.INNER_WSTRB  = io_bus.S_WSTRB;
endmodule

// File: tb/tb_axi4_slave_write_channel.sv
// Randomized bench for axi4_slave_write_channel; expected beats and responses come from a
// burst-level model (address list, data queue, error rule) kept in this file.
module tb_axi4_slave_write_channel;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SB = DW / 8;
`ifdef AXI4_SLAVE_WR_PROTOCOL_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic ACLK = 1'b0;
  logic ARESETN = 1'b0;
  always #5 ACLK = ~ACLK;

  axi4_slave_write_channel_if #(.AddressWidth(AW), .DataWidth(DW)) bus ();

  axi4_slave_write_channel #(.AddressWidth(AW), .DataWidth(DW)) dut (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .io_bus  (bus.slave)
  );

  int errors = 0;
  int checks = 0;

  logic [AW-1:0] obs_addr[$];
  logic [DW-1:0] obs_data[$];
  logic          obs_last[$];
  logic [DW-1:0] sent_data[$];

  // Runs one burst. wlast_at: beat index carrying S_WLAST; mode 0 ready, 1 toggle, 2 random.
  task automatic do_burst(input logic [AW-1:0] addr, input int len, input logic [1:0] burst,
                          input int wlast_at, input int mode, input int stall,
                          input bit pend, input bit aw_pre);
    int k;
    int cyc;
    bit drain;
    bit ready_t;
    logic [1:0] exp_resp;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] d;
    drain    = CHK && burst[1];
    exp_resp = (CHK && (burst[1] || wlast_at != len)) ? 2'b10 : 2'b00;
    obs_addr.delete(); obs_data.delete(); obs_last.delete(); sent_data.delete();
    bus.S_AWADDR  = addr;
    bus.S_AWLEN   = len[7:0];
    bus.S_AWSIZE  = 3'd2;
    bus.S_AWBURST = burst;
    if (!aw_pre) begin
      bus.S_AWVALID = 1'b1;
      cyc = 0;
      do begin
        @(negedge ACLK);
        cyc++;
      end while (!bus.S_AWREADY && cyc < 20);
      checks++;
      if (bus.S_AWREADY !== 1'b1) begin
        errors++;
        $display("FAIL aw_accept: S_AWREADY=%0b expected 1", bus.S_AWREADY);
      end
      @(posedge ACLK); #1;
      bus.S_AWVALID = 1'b0;
    end
    k = 0; cyc = 0; ready_t = 1'b1;
    while (k <= len && cyc < 10 * (len + 1) + 50) begin
      bus.S_WVALID = (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
      d = $urandom;
      bus.S_WDATA = d;
      bus.S_WSTRB = 4'($urandom);
      bus.S_WLAST = (k == wlast_at);
      bus.INNER_WREADY = (mode == 0) ? 1'b1 : (mode == 1) ? ready_t : 1'($urandom_range(0, 1));
      ready_t = ~ready_t;
      @(negedge ACLK);
      cyc++;
      checks++;
      if (bus.S_WREADY !== (drain ? 1'b1 : bus.INNER_WREADY)) begin
        errors++;
        $display("FAIL w_ready beat %0d: S_WREADY=%0b expected %0b", k, bus.S_WREADY,
                 drain ? 1'b1 : bus.INNER_WREADY);
      end
      checks++;
      if (bus.INNER_WVALID !== (bus.S_WVALID && !drain)) begin
        errors++;
        $display("FAIL inner_wvalid beat %0d: INNER_WVALID=%0b expected %0b", k,
                 bus.INNER_WVALID, bus.S_WVALID && !drain);
      end
      if (bus.INNER_WVALID && bus.INNER_WREADY) begin
        obs_addr.push_back(bus.INNER_WADDR);
        obs_data.push_back(bus.INNER_WDATA);
        obs_last.push_back(bus.INNER_WLAST);
        checks++;
        if (bus.INNER_WSTRB !== bus.S_WSTRB) begin
          errors++;
          $display("FAIL inner_wstrb: got %h expected %h", bus.INNER_WSTRB, bus.S_WSTRB);
        end
      end
      if (bus.S_WVALID && bus.S_WREADY) begin
        sent_data.push_back(d);
        k++;
      end
      @(posedge ACLK); #1;
    end
    bus.S_WVALID = 1'b0;
    bus.S_WLAST  = 1'b0;
    checks++;
    if (k != len + 1) begin
      errors++;
      $display("FAIL burst_timeout: accepted %0d beats expected %0d", k, len + 1);
    end
    if (pend) bus.S_AWVALID = 1'b1;
    for (int i = 0; i <= stall; i++) begin
      bus.S_BREADY = (i == stall);
      @(negedge ACLK);
      checks++;
      if (bus.S_BVALID !== 1'b1 || bus.S_BRESP !== exp_resp) begin
        errors++;
        $display("FAIL b_resp cycle %0d: BVALID=%0b BRESP=%b expected 1/%b", i,
                 bus.S_BVALID, bus.S_BRESP, exp_resp);
      end
      checks++;
      if (bus.S_AWREADY !== 1'b0) begin
        errors++;
        $display("FAIL aw_blocked cycle %0d: S_AWREADY=%0b expected 0", i, bus.S_AWREADY);
      end
      @(posedge ACLK); #1;
    end
    bus.S_BREADY = 1'b0;
    @(negedge ACLK);
    checks++;
    if (bus.S_BVALID !== 1'b0 || bus.S_AWREADY !== 1'b1) begin
      errors++;
      $display("FAIL b_done: BVALID=%0b AWREADY=%0b expected 0/1", bus.S_BVALID, bus.S_AWREADY);
    end
    @(posedge ACLK); #1;
    if (pend) bus.S_AWVALID = 1'b0;
    // Model: one inner beat per W beat unless drained
    checks++;
    if (obs_addr.size() != (drain ? 0 : len + 1)) begin
      errors++;
      $display("FAIL beat_count: got %0d expected %0d", obs_addr.size(), drain ? 0 : len + 1);
    end
    for (int i = 0; i < obs_addr.size() && i <= len; i++) begin
      exp_addr = (burst == 2'b00) ? addr : addr + AW'(i * SB);
      checks++;
      if (obs_addr[i] !== exp_addr || obs_data[i] !== sent_data[i] ||
          obs_last[i] !== (i == len)) begin
        errors++;
        $display("FAIL beat %0d: addr=%h data=%h last=%0b expected %h/%h/%0b", i, obs_addr[i],
                 obs_data[i], obs_last[i], exp_addr, sent_data[i], (i == len));
      end
    end
  endtask

  task automatic test_reset();
    ARESETN = 1'b0;
    bus.S_WVALID = 1'b1;
    repeat (2) @(posedge ACLK);
    @(negedge ACLK);
    checks++;
    if (bus.S_AWREADY !== 1'b1 || bus.S_WREADY !== 1'b0 || bus.S_BVALID !== 1'b0 ||
        bus.S_BRESP !== 2'b00 || bus.INNER_WVALID !== 1'b0 || bus.INNER_WLAST !== 1'b0 ||
        bus.INNER_WADDR !== 32'h0) begin
      errors++;
      $display("FAIL reset_values: AWREADY=%0b WREADY=%0b BVALID=%0b BRESP=%b IWVALID=%0b IWLAST=%0b IWADDR=%h",
               bus.S_AWREADY, bus.S_WREADY, bus.S_BVALID, bus.S_BRESP, bus.INNER_WVALID,
               bus.INNER_WLAST, bus.INNER_WADDR);
    end
    @(posedge ACLK); #1;
    ARESETN = 1'b1;
    @(negedge ACLK);
    checks++;
    if (bus.S_WREADY !== 1'b0 || bus.INNER_WVALID !== 1'b0) begin
      errors++;
      $display("FAIL idle_w_ignored: WREADY=%0b INNER_WVALID=%0b expected 0/0",
               bus.S_WREADY, bus.INNER_WVALID);
    end
    @(posedge ACLK); #1;
    bus.S_WVALID = 1'b0;
  endtask

  task automatic test_incr();
    do_burst(32'h1000, 3, 2'b01, 3, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_fixed();
    do_burst(32'h20, 2, 2'b00, 2, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_toggle_ready();
    do_burst(32'h4000, 7, 2'b01, 7, 1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_addr_wrap();
    do_burst(32'hFFFF_FFFC, 1, 2'b01, 1, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_bready_stall();
    do_burst(32'h400, 1, 2'b01, 1, 0, 5, 1'b1, 1'b0);
    do_burst(32'h400, 1, 2'b01, 1, 0, 0, 1'b0, 1'b1);
  endtask

  task automatic test_long_burst();
    do_burst(32'h8000, 255, 2'b01, 255, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_protocol();
    do_burst(32'h100, 3, 2'b01, 1, 0, 0, 1'b0, 1'b0);
    do_burst(32'h200, 3, 2'b11, 3, 0, 0, 1'b0, 1'b0);
    do_burst(32'h300, 2, 2'b10, 2, 2, 1, 1'b0, 1'b0);
    do_burst(32'h340, 2, 2'b01, 7, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    int len;
    for (int n = 0; n < 25; n++) begin
      len = $urandom_range(0, 15);
      do_burst({$urandom} & 32'hFFFF_FFFC, len, 2'($urandom_range(0, 3)),
               ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 15)) : len,
               2, $urandom_range(0, 3), 1'b0, 1'b0);
    end
  endtask

  task automatic test_mid_reset();
    bus.S_AWADDR = 32'h800; bus.S_AWLEN = 8'd5; bus.S_AWBURST = 2'b01; bus.S_AWVALID = 1'b1;
    @(posedge ACLK); #1;
    bus.S_AWVALID = 1'b0;
    bus.S_WVALID = 1'b1; bus.S_WLAST = 1'b0; bus.INNER_WREADY = 1'b1;
    repeat (2) @(posedge ACLK);
    #1;
    ARESETN = 1'b0;
    @(posedge ACLK); #1;
    @(negedge ACLK);
    checks++;
    if (bus.S_AWREADY !== 1'b1 || bus.S_BVALID !== 1'b0 || bus.INNER_WVALID !== 1'b0 ||
        bus.S_WREADY !== 1'b0 || bus.INNER_WADDR !== 32'h0) begin
      errors++;
      $display("FAIL mid_reset: AWREADY=%0b BVALID=%0b IWVALID=%0b WREADY=%0b IWADDR=%h",
               bus.S_AWREADY, bus.S_BVALID, bus.INNER_WVALID, bus.S_WREADY, bus.INNER_WADDR);
    end
    @(posedge ACLK); #1;
    ARESETN = 1'b1;
    bus.S_WVALID = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge ACLK);
      checks++;
      if (bus.S_BVALID !== 1'b0 || bus.S_AWREADY !== 1'b1) begin
        errors++;
        $display("FAIL post_reset_idle cycle %0d: BVALID=%0b AWREADY=%0b expected 0/1",
                 i, bus.S_BVALID, bus.S_AWREADY);
      end
    end
    @(posedge ACLK); #1;
  endtask

  initial begin
    bus.S_AWADDR = '0; bus.S_AWLEN = 8'd0; bus.S_AWSIZE = 3'd2; bus.S_AWBURST = 2'b01;
    bus.S_AWVALID = 1'b0; bus.S_WDATA = '0; bus.S_WSTRB = '0; bus.S_WLAST = 1'b0;
    bus.S_WVALID = 1'b0; bus.S_BREADY = 1'b0; bus.INNER_WREADY = 1'b0;
    test_reset();
    test_incr();
    test_fixed();
    test_toggle_ready();
    test_addr_wrap();
    test_bready_stall();
    test_long_burst();
    test_protocol();
    test_random();
    test_mid_reset();
    test_incr();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
